// File: rtl/lcd_capture.sv
// Grabs one RGB888 DEN/VD frame, decimates 2:1 in both axes and writes RGB565 into the frame store.
// Two-edge pin-to-write latency; at most one write per two pixels, none on odd rows.
module lcd_capture #(
  parameter int H_ACT = 800,
  parameter int V_ACT = 480,
  parameter bit CONT  = 1'b0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ARM,
  input  logic        VD,
  input  logic        DEN,
  input  logic [7:0]  R,
  input  logic [7:0]  G,
  input  logic [7:0]  B,
  output logic        WE,
  output logic [19:0] WADDR,
  output logic [15:0] WDATA,
  output logic        BUSY,
  output logic        FRAME_DONE,
  output logic        OVF
);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

  localparam logic [9:0] H_LIM = 10'(H_ACT);
  localparam logic [8:0] V_LIM = 9'(V_ACT);

  state_t      state_q, state_d;
  logic        vd_r_q, vd_rr_q, den_r_q, den_rr_q;
  logic [15:0] pix_r_q;
  logic [9:0]  col_q, col_d;
  logic [8:0]  row_q, row_d;
  logic        ovf_q, ovf_d;
  logic        we_q;
  logic [19:0] waddr_q;
  logic [15:0] wdata_q;

  logic        vd_fall, den_fall, in_win, wr_ok;
  logic [8:0]  row_cur;
  logic        unused_lsbs;

  // The low colour bits are dropped by the RGB565 packing.
  assign unused_lsbs = ^{R[2:0], G[1:0], B[2:0]};

  assign vd_fall  = vd_rr_q & ~vd_r_q;
  assign den_fall = den_rr_q & ~den_r_q;
  // A frame start coinciding with a pixel puts that pixel on row 0.
  assign row_cur  = vd_fall ? 9'd0 : row_q;
  assign in_win   = (col_q < H_LIM) && (row_cur < V_LIM);
  assign wr_ok    = (state_q == CAPTURE) && den_r_q && !col_q[0] && !row_cur[0] && in_win;

  always_comb begin
    col_d = 10'd0;
    if (den_r_q) col_d = (col_q == 10'h3FF) ? col_q : col_q + 10'd1;

    row_d = row_q;
    if (vd_fall) row_d = 9'd0;
    else if (den_fall && row_q != 9'h1FF) row_d = row_q + 9'd1;
  end

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (ARM) begin
          state_d = WAIT_VS;
          ovf_d   = 1'b0;
        end
      end
      WAIT_VS: if (vd_fall) state_d = CAPTURE;
      CAPTURE: begin
        if (vd_fall) state_d = DONE;
        if (den_r_q && !in_win) ovf_d = 1'b1;
      end
      DONE:    state_d = CONT ? CAPTURE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      vd_r_q   <= 1'b0;
      vd_rr_q  <= 1'b0;
      den_r_q  <= 1'b0;
      den_rr_q <= 1'b0;
      pix_r_q  <= 16'd0;
      col_q    <= 10'd0;
      row_q    <= 9'd0;
      ovf_q    <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= 20'd0;
      wdata_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      vd_r_q   <= VD;
      vd_rr_q  <= vd_r_q;
      den_r_q  <= DEN;
      den_rr_q <= den_r_q;
      pix_r_q  <= {R[7:3], G[7:2], B[7:3]};
      col_q    <= col_d;
      row_q    <= row_d;
      ovf_q    <= ovf_d;
      we_q     <= wr_ok;
      if (wr_ok) begin
        waddr_q <= {3'b000, row_cur[8:1], col_q[9:1]};
        wdata_q <= pix_r_q;
      end
    end
  end

  assign WE         = we_q;
  assign WADDR      = waddr_q;
  assign WDATA      = wdata_q;
  assign OVF        = ovf_q;
  assign FRAME_DONE = (state_q == DONE);
  // In continuous mode the DONE cycle is part of an uninterrupted capture.
  assign BUSY       = (state_q == WAIT_VS) || (state_q == CAPTURE) || (CONT && state_q == DONE);

endmodule

// File: tb/tb_lcd_capture.sv
// Bench for lcd_capture: a single-shot and a continuous instance share one video source;
// expected writes come from a frame-level model of the decimation and packing rules.
module tb_lcd_capture;

  localparam int HA = 16;
  localparam int VA = 12;

  typedef struct packed {
    logic [19:0] a;
    logic [15:0] d;
    logic [31:0] t;
  } wr_t;

  logic        CLK = 1'b0, RST_N = 1'b0, ARM0 = 1'b0, ARM1 = 1'b0, VD = 1'b1, DEN = 1'b0;
  logic [7:0]  R = 8'd0, G = 8'd0, B = 8'd0;
  logic        WE0, WE1, BUSY0, BUSY1, FD0, FD1, OVF0, OVF1;
  logic [19:0] WADDR0, WADDR1;
  logic [15:0] WDATA0, WDATA1;

  wr_t got0[$], got1[$], exp0[$], exp1[$];
  int  total = 0, bad = 0;
  int  cycle = 0, vs_cycle = 0;
  int  fd0_n = 0, fd1_n = 0, fd0_t = 0, busy1_low = 0;
  bit  busy_watch = 0;

  lcd_capture #(.H_ACT(HA), .V_ACT(VA), .CONT(1'b0)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .ARM(ARM0), .VD(VD), .DEN(DEN), .R(R), .G(G), .B(B),
    .WE(WE0), .WADDR(WADDR0), .WDATA(WDATA0), .BUSY(BUSY0), .FRAME_DONE(FD0), .OVF(OVF0));

  lcd_capture #(.H_ACT(HA), .V_ACT(VA), .CONT(1'b1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .ARM(ARM1), .VD(VD), .DEN(DEN), .R(R), .G(G), .B(B),
    .WE(WE1), .WADDR(WADDR1), .WDATA(WDATA1), .BUSY(BUSY1), .FRAME_DONE(FD1), .OVF(OVF1));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cycle <= cycle + 1;

  always @(negedge CLK) begin
    if (WE0 === 1'b1) got0.push_back('{WADDR0, WDATA0, 32'(cycle)});
    if (WE1 === 1'b1) got1.push_back('{WADDR1, WDATA1, 32'(cycle)});
    if (FD0 === 1'b1) begin fd0_n++; fd0_t = cycle; end
    if (FD1 === 1'b1) fd1_n++;
    if (busy_watch && BUSY1 !== 1'b1) busy1_low++;
  end

  task automatic cyc(input logic vd, input logic den, input logic [23:0] rgb);
    @(negedge CLK);
    VD = vd; DEN = den; {R, G, B} = rgb;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b0, 24'h0);
  endtask

  task automatic vsync();
    cyc(1'b0, 1'b0, 24'h0);
    vs_cycle = cycle;
    cyc(1'b0, 1'b0, 24'h0);
    idle(3);
  endtask

  task automatic arm(input bit a0, input bit a1);
    @(negedge CLK); ARM0 = a0; ARM1 = a1;
    @(negedge CLK); ARM0 = 1'b0; ARM1 = 1'b0;
  endtask

  // mode 0: random pixels, 1: pixel value = column, 2: constant FF/80/07
  task automatic line(input int len, input int row, input int mode, input bit e0, input bit e1);
    logic [23:0] px;
    wr_t w;
    for (int c = 0; c < len; c++) begin
      case (mode)
        0:       px = 24'($urandom);
        1:       px = {3{8'(c)}};
        default: px = 24'hFF8007;
      endcase
      cyc(1'b1, 1'b1, px);
      if (row % 2 == 0 && c % 2 == 0 && row < VA && c < HA) begin
        w.a = 20'((row / 2) * 512 + c / 2);
        w.d = 16'(((int'(px[23:16]) / 8) * 2048) + ((int'(px[15:8]) / 4) * 32) + (int'(px[7:0]) / 8));
        w.t = 32'(cycle + 2);
        if (e0) exp0.push_back(w);
        if (e1) exp1.push_back(w);
      end
    end
    idle(3);
  endtask

  task automatic frame(input int nl, input int len, input int mode, input bit e0, input bit e1);
    for (int r = 0; r < nl; r++) line(len, r, mode, e0, e1);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0; ARM0 = 1'b0; ARM1 = 1'b0; VD = 1'b1; DEN = 1'b0;
    repeat (3) @(negedge CLK);
    got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
    fd0_n = 0; fd1_n = 0; busy1_low = 0; busy_watch = 0;
    RST_N = 1'b1;
    idle(2);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (8) cyc(1'($urandom), 1'($urandom), 24'($urandom));
    total += 8;
    if (WE0 !== 1'b0)   begin bad++; $display("FAIL reset_we0: got %b want 0", WE0); end
    if (BUSY0 !== 1'b0) begin bad++; $display("FAIL reset_busy0: got %b want 0", BUSY0); end
    if (OVF0 !== 1'b0)  begin bad++; $display("FAIL reset_ovf0: got %b want 0", OVF0); end
    if (FD0 !== 1'b0)   begin bad++; $display("FAIL reset_fd0: got %b want 0", FD0); end
    if (WE1 !== 1'b0)   begin bad++; $display("FAIL reset_we1: got %b want 0", WE1); end
    if (BUSY1 !== 1'b0) begin bad++; $display("FAIL reset_busy1: got %b want 0", BUSY1); end
    if (OVF1 !== 1'b0)  begin bad++; $display("FAIL reset_ovf1: got %b want 0", OVF1); end
    if (FD1 !== 1'b0)   begin bad++; $display("FAIL reset_fd1: got %b want 0", FD1); end
    @(negedge CLK); RST_N = 1'b1; VD = 1'b1; DEN = 1'b0;
    idle(2);
    vsync(); frame(4, HA, 0, 1'b0, 1'b0); vsync(); idle(3);
    total += 3;
    if (got0.size() != 0) begin bad++; $display("FAIL noarm_writes0: got %0d want 0", got0.size()); end
    if (got1.size() != 0) begin bad++; $display("FAIL noarm_writes1: got %0d want 0", got1.size()); end
    if (fd0_n + fd1_n != 0) begin bad++; $display("FAIL noarm_done: got %0d want 0", fd0_n + fd1_n); end
  endtask

  task automatic test_single_line();
    do_reset();
    arm(1'b1, 1'b0);
    line(6, 0, 0, 1'b0, 1'b0);          // partial frame while waiting for VD
    vsync();
    line(8, 0, 2, 1'b1, 1'b0);
    line(8, 1, 2, 1'b1, 1'b0);
    vsync(); idle(3);
    total++;
    if (got0.size() != 4) begin bad++; $display("FAIL line_count: got %0d want 4", got0.size()); end
    for (int i = 0; i < exp0.size() && i < got0.size(); i++) begin
      total++;
      if (got0[i] !== exp0[i]) begin
        bad++;
        $display("FAIL line_wr[%0d]: got a=%h d=%h t=%0d want a=%h d=%h t=%0d",
                 i, got0[i].a, got0[i].d, got0[i].t, exp0[i].a, exp0[i].d, exp0[i].t);
      end
    end
    if (got0.size() == 4) begin
      total++;
      if (got0[3].a !== 20'h3 || got0[3].d !== 16'hFC00) begin
        bad++; $display("FAIL line_last: got a=%h d=%h want a=00003 d=fc00", got0[3].a, got0[3].d);
      end
    end
    total += 2;
    if (fd0_n != 1) begin bad++; $display("FAIL line_done: got %0d want 1", fd0_n); end
    if (OVF0 !== 1'b0) begin bad++; $display("FAIL line_ovf: got %b want 0", OVF0); end
  endtask

  task automatic test_full_frame();
    do_reset();
    arm(1'b1, 1'b0);
    vsync();
    line(HA, 0, 1, 1'b1, 1'b0);
    total++;
    if (BUSY0 !== 1'b1) begin bad++; $display("FAIL full_busy_mid: got %b want 1", BUSY0); end
    for (int r = 1; r < VA; r++) line(HA, r, 1, 1'b1, 1'b0);
    vsync(); idle(3);
    total += 5;
    if (got0.size() != 48) begin bad++; $display("FAIL full_count: got %0d want 48", got0.size()); end
    if (got0.size() > 0 && got0[got0.size()-1].a !== 20'h00A07) begin
      bad++; $display("FAIL full_last_addr: got %h want 00a07", got0[got0.size()-1].a);
    end
    if (fd0_n != 1) begin bad++; $display("FAIL full_done_n: got %0d want 1", fd0_n); end
    if (fd0_t != vs_cycle + 2) begin bad++; $display("FAIL full_done_t: got %0d want %0d", fd0_t, vs_cycle + 2); end
    if (BUSY0 !== 1'b0) begin bad++; $display("FAIL full_busy_end: got %b want 0", BUSY0); end
    for (int i = 0; i < exp0.size() && i < got0.size(); i++) begin
      total++;
      if (got0[i] !== exp0[i]) begin
        bad++;
        $display("FAIL full_wr[%0d]: got a=%h d=%h t=%0d want a=%h d=%h t=%0d",
                 i, got0[i].a, got0[i].d, got0[i].t, exp0[i].a, exp0[i].d, exp0[i].t);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_a;
    do_reset();
    arm(1'b0, 1'b1);
    busy_watch = 1;
    vsync();
    frame(4, HA, 0, 1'b0, 1'b1);
    n_a = exp1.size();
    vsync();
    frame(4, HA, 0, 1'b0, 1'b1);
    vsync();
    busy_watch = 0;
    idle(3);
    total += 5;
    if (fd1_n != 2) begin bad++; $display("FAIL cont_done: got %0d want 2", fd1_n); end
    if (busy1_low != 0) begin bad++; $display("FAIL cont_busy: got %0d low cycles want 0", busy1_low); end
    if (fd0_n != 0) begin bad++; $display("FAIL cont_unarmed_done: got %0d want 0", fd0_n); end
    if (got1.size() != exp1.size()) begin bad++; $display("FAIL cont_count: got %0d want %0d", got1.size(), exp1.size()); end
    if (got1.size() > n_a && got1[n_a].a !== 20'h0) begin
      bad++; $display("FAIL cont_restart: got %h want 00000", got1[n_a].a);
    end
    for (int i = 0; i < exp1.size() && i < got1.size(); i++) begin
      total++;
      if (got1[i] !== exp1[i]) begin
        bad++;
        $display("FAIL cont_wr[%0d]: got a=%h d=%h t=%0d want a=%h d=%h t=%0d",
                 i, got1[i].a, got1[i].d, got1[i].t, exp1[i].a, exp1[i].d, exp1[i].t);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    arm(1'b1, 1'b0);
    vsync();
    line(HA + 10, 0, 0, 1'b1, 1'b0);
    total++;
    if (OVF0 !== 1'b1) begin bad++; $display("FAIL ovf_col_set: got %b want 1", OVF0); end
    line(8, 1, 0, 1'b1, 1'b0);
    vsync(); idle(3);
    total += 3;
    if (fd0_n != 1) begin bad++; $display("FAIL ovf_done: got %0d want 1", fd0_n); end
    if (OVF0 !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", OVF0); end
    if (got0.size() != exp0.size()) begin bad++; $display("FAIL ovf_count: got %0d want %0d", got0.size(), exp0.size()); end
    for (int i = 0; i < exp0.size() && i < got0.size(); i++) begin
      total++;
      if (got0[i] !== exp0[i]) begin
        bad++;
        $display("FAIL ovf_wr[%0d]: got a=%h d=%h want a=%h d=%h", i, got0[i].a, got0[i].d, exp0[i].a, exp0[i].d);
      end
    end
    arm(1'b1, 1'b0);
    idle(1);
    total += 2;
    if (OVF0 !== 1'b0) begin bad++; $display("FAIL ovf_arm_clear: got %b want 0", OVF0); end
    if (BUSY0 !== 1'b1) begin bad++; $display("FAIL ovf_rearm_busy: got %b want 1", BUSY0); end
    got0.delete(); exp0.delete();
    vsync();
    frame(VA + 2, HA, 0, 1'b1, 1'b0);
    vsync(); idle(3);
    total += 2;
    if (OVF0 !== 1'b1) begin bad++; $display("FAIL ovf_row_set: got %b want 1", OVF0); end
    if (got0.size() != exp0.size()) begin bad++; $display("FAIL ovf_row_count: got %0d want %0d", got0.size(), exp0.size()); end
    for (int i = 0; i < exp0.size() && i < got0.size(); i++) begin
      total++;
      if (got0[i] !== exp0[i]) begin
        bad++;
        $display("FAIL ovf_row_wr[%0d]: got a=%h d=%h want a=%h d=%h", i, got0[i].a, got0[i].d, exp0[i].a, exp0[i].d);
      end
    end
  endtask

  task automatic test_reset_mid_line();
    do_reset();
    arm(1'b1, 1'b0);
    vsync();
    for (int c = 0; c <= 6; c++) cyc(1'b1, 1'b1, 24'($urandom));
    total++;
    if (WE0 !== 1'b1) begin bad++; $display("FAIL mid_we_before: got %b want 1", WE0); end
    #1 RST_N = 1'b0;
    #1;
    total += 2;
    if (WE0 !== 1'b0) begin bad++; $display("FAIL mid_we_async: got %b want 0", WE0); end
    if (BUSY0 !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", BUSY0); end
    cyc(1'b1, 1'b0, 24'h0);
    cyc(1'b1, 1'b0, 24'h0);
    RST_N = 1'b1;
    got0.delete(); exp0.delete();
    idle(2);
    vsync(); frame(2, HA, 0, 1'b0, 1'b0); vsync();
    total++;
    if (got0.size() != 0) begin bad++; $display("FAIL mid_noarm: got %0d writes want 0", got0.size()); end
    arm(1'b1, 1'b0);
    vsync(); frame(4, HA, 0, 1'b1, 1'b0); vsync(); idle(3);
    total += 3;
    if (got0.size() != exp0.size()) begin bad++; $display("FAIL mid_count: got %0d want %0d", got0.size(), exp0.size()); end
    if (got0.size() > 0 && got0[0].a !== 20'h0) begin bad++; $display("FAIL mid_first_addr: got %h want 00000", got0[0].a); end
    if (fd0_n != 1) begin bad++; $display("FAIL mid_done: got %0d want 1", fd0_n); end
    for (int i = 0; i < exp0.size() && i < got0.size(); i++) begin
      total++;
      if (got0[i] !== exp0[i]) begin
        bad++;
        $display("FAIL mid_wr[%0d]: got a=%h d=%h t=%0d want a=%h d=%h t=%0d",
                 i, got0[i].a, got0[i].d, got0[i].t, exp0[i].a, exp0[i].d, exp0[i].t);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_full_frame();
    test_back_to_back();
    test_overflow();
    test_reset_mid_line();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
